dma_copy: RTL and testbench

- Word-granular memory-to-memory copy engine.
- Acts as a responder on the CPU peripheral bus, at a 5-bit register window.
- Acts as a second initiator on the shared 16-bit system bus, behind the bus arbiter.
- Lets firmware move blocks (e.g. BRAM -> SPRAM, SPI flash -> SPRAM) without CPU load/store loops; raises a level interrupt on completion.

---
 rtl/dma_copy.sv | 236 +++++++++++++++++++++++
 tb/tb_dma_copy.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy.sv
// dma_copy: word-granular memory-to-memory copy engine.
//   Register responder on the CPU peripheral bus (5-bit byte window) and a
//   second initiator on the shared 16-bit system bus behind the arbiter.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_addr/s_ren/s_rdata/s_rd_valid register read port (1-cycle latency)
//   s_wen/s_wdata                  register write port
//   m_req/m_grant                  arbiter handshake, bus held for a whole block
//   m_addr/m_ren/m_rdata/m_rd_valid system bus read (held until valid)
//   m_wen/m_wdata/m_wmask          system bus write (single-cycle strobe)
//   irq                            level interrupt, done & irq_en
// Register map: 0x00 SRC, 0x04 DST, 0x08 LEN (words), 0x0C CTRL/STATUS,
//   0x10 REMAIN. CTRL write: start, irq_en, clear_done, abort (bits 0..3).
//   STATUS read: {error, irq_en, done, busy} in bits 3..0.
module dma_copy #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   s_addr,
  input  logic         s_ren,
  output logic [W-1:0] s_rdata,
  output logic         s_rd_valid,
  input  logic         s_wen,
  input  logic [W-1:0] s_wdata,
  output logic         m_req,
  input  logic         m_grant,
  output logic [15:0]  m_addr,
  output logic         m_ren,
  input  logic [W-1:0] m_rdata,
  input  logic         m_rd_valid,
  output logic         m_wen,
  output logic [W-1:0] m_wdata,
  output logic [3:0]   m_wmask,
  output logic         irq
);

  localparam int unsigned AW = 16;
  localparam int unsigned TW = 8;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [4:0] A_SRC    = 5'h00;
  localparam logic [4:0] A_DST    = 5'h04;
  localparam logic [4:0] A_LEN    = 5'h08;
  localparam logic [4:0] A_CTRL   = 5'h0C;
  localparam logic [4:0] A_REMAIN = 5'h10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state, state_n;
  logic [AW-1:0] src_reg, src_reg_n, dst_reg, dst_reg_n, len_reg, len_reg_n;
  logic [AW-1:0] src, src_n, dst, dst_n, remain, remain_n;
  logic [W-1:0]  data, data_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          irq_en, irq_en_n, done, done_n, error, error_n;
  logic          abort_pend, abort_n;
  logic          m_req_n, m_ren_n, m_wen_n;
  logic [AW-1:0] m_addr_n;
  logic [W-1:0]  m_wdata_n, s_rdata_n;
  logic [3:0]    m_wmask_n;
  logic          s_rd_valid_n;

  logic busy, ctrl_wr, start_req, abort_now;
  logic unused_wdata;

  assign busy      = (state != S_IDLE);
  assign ctrl_wr   = s_wen && (s_addr == A_CTRL);
  assign start_req = ctrl_wr && s_wdata[0];
  assign abort_now = ctrl_wr && s_wdata[3];

  assign irq          = done & irq_en;
  assign unused_wdata = ^s_wdata[W-1:AW];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      src        <= '0;
      dst        <= '0;
      remain     <= '0;
      data       <= '0;
      tcnt       <= '0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      abort_pend <= 1'b0;
      m_req      <= 1'b0;
      m_ren      <= 1'b0;
      m_wen      <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wmask    <= '0;
      s_rdata    <= '0;
      s_rd_valid <= 1'b0;
    end else begin
      state      <= state_n;
      src_reg    <= src_reg_n;
      dst_reg    <= dst_reg_n;
      len_reg    <= len_reg_n;
      src        <= src_n;
      dst        <= dst_n;
      remain     <= remain_n;
      data       <= data_n;
      tcnt       <= tcnt_n;
      irq_en     <= irq_en_n;
      done       <= done_n;
      error      <= error_n;
      abort_pend <= abort_n;
      m_req      <= m_req_n;
      m_ren      <= m_ren_n;
      m_wen      <= m_wen_n;
      m_addr     <= m_addr_n;
      m_wdata    <= m_wdata_n;
      m_wmask    <= m_wmask_n;
      s_rdata    <= s_rdata_n;
      s_rd_valid <= s_rd_valid_n;
    end
  end

  // Next state, register updates and next-cycle bus outputs
  always_comb begin
    state_n   = state;
    src_reg_n = src_reg;
    dst_reg_n = dst_reg;
    len_reg_n = len_reg;
    src_n     = src;
    dst_n     = dst;
    remain_n  = remain;
    data_n    = data;
    tcnt_n    = tcnt;
    irq_en_n  = irq_en;
    done_n    = done;
    error_n   = error;
    abort_n   = abort_pend;

    // Block configuration is frozen while a transfer is in flight
    if (s_wen && !busy) begin
      case (s_addr)
        A_SRC:   src_reg_n = {s_wdata[AW-1:2], 2'b00};
        A_DST:   dst_reg_n = {s_wdata[AW-1:2], 2'b00};
        A_LEN:   len_reg_n = s_wdata[AW-1:0];
        default: ;
      endcase
    end

    if (ctrl_wr) begin
      irq_en_n = s_wdata[1];
      if (s_wdata[2]) done_n = 1'b0;
      if (s_wdata[3] && busy) abort_n = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start_req) begin
          src_n    = src_reg;
          dst_n    = dst_reg;
          remain_n = len_reg;
          done_n   = 1'b0;
          error_n  = 1'b0;
          abort_n  = 1'b0;
          state_n  = (len_reg == '0) ? S_DONE : S_ARB;
        end
      end
      S_ARB: begin
        if (abort_pend || abort_now) begin
          state_n = S_DONE;
        end else if (m_grant) begin
          tcnt_n  = '0;
          state_n = S_READ;
        end
      end
      S_READ: begin
        if (m_rd_valid) begin
          data_n  = m_rdata;
          state_n = S_WRITE;
        end else if (tcnt == T_LAST) begin
          error_n = 1'b1;
          state_n = S_DONE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      S_WRITE: begin
        src_n    = src + AW'(4);
        dst_n    = dst + AW'(4);
        remain_n = remain - AW'(1);
        if (remain == AW'(1) || abort_pend || abort_now) begin
          state_n = S_DONE;
        end else begin
          tcnt_n  = '0;
          state_n = S_READ;
        end
      end
      S_DONE: begin
        // Completion overrides a clear_done arriving in the same cycle
        done_n  = 1'b1;
        abort_n = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Bus outputs are registered from the state being entered
    m_req_n   = (state_n == S_ARB) || (state_n == S_READ) || (state_n == S_WRITE);
    m_ren_n   = (state_n == S_READ);
    m_wen_n   = (state_n == S_WRITE);
    m_addr_n  = (state_n == S_READ)  ? src_n :
                (state_n == S_WRITE) ? dst_n : '0;
    m_wdata_n = (state_n == S_WRITE) ? data_n : '0;
    m_wmask_n = (state_n == S_WRITE) ? 4'hF : 4'h0;

    // Register read port
    s_rd_valid_n = s_ren;
    s_rdata_n    = '0;
    if (s_ren) begin
      case (s_addr)
        A_SRC:    s_rdata_n = W'(src_reg);
        A_DST:    s_rdata_n = W'(dst_reg);
        A_LEN:    s_rdata_n = W'(len_reg);
        A_CTRL:   s_rdata_n = W'({error, irq_en, done, busy});
        A_REMAIN: s_rdata_n = W'(remain);
        default:  s_rdata_n = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: register-map vector table, directed
// corner sequences and randomized block copies checked against a word-level
// memory model.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  s_addr;
  logic        s_ren;
  logic [31:0] s_rdata;
  logic        s_rd_valid;
  logic        s_wen;
  logic [31:0] s_wdata;
  logic        m_req;
  logic        m_grant;
  logic [15:0] m_addr;
  logic        m_ren;
  logic [31:0] m_rdata;
  logic        m_rd_valid;
  logic        m_wen;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic        irq;

  always #5 clk = ~clk;

  dma_copy #(.W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_addr(s_addr), .s_ren(s_ren), .s_rdata(s_rdata), .s_rd_valid(s_rd_valid),
    .s_wen(s_wen), .s_wdata(s_wdata),
    .m_req(m_req), .m_grant(m_grant), .m_addr(m_addr), .m_ren(m_ren),
    .m_rdata(m_rdata), .m_rd_valid(m_rd_valid),
    .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask), .irq(irq)
  );

  localparam logic [4:0] R_SRC = 5'h00, R_DST = 5'h04, R_LEN = 5'h08,
                         R_CTRL = 5'h0C, R_REMAIN = 5'h10;

  int n_tests = 0;
  int n_fail  = 0;

  // System memory seen by the bus, and the reference copy of it
  logic [31:0] mem     [16384];
  logic [31:0] ref_mem [16384];

  // Responder configuration and bus monitor state
  int lat = 1, gdelay = 0;
  bit never_resp = 0;
  int cyc = 0, rcnt = 0, gcnt = 0;
  int wr_count = 0, req_cycles = 0, ren_cycles = 0, bad_mask = 0;
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];
  int          wr_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Arbiter + memory responder + bus monitor, driven away from the rising edge
  initial begin
    m_grant = 1'b0; m_rd_valid = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_grant = 1'b0; m_rd_valid = 1'b0; rcnt = 0; gcnt = 0;
      end else begin
        if (m_req) begin
          gcnt++;
          m_grant = (gcnt > gdelay);
          req_cycles++;
        end else begin
          gcnt = 0;
          m_grant = 1'b0;
        end
        if (m_rd_valid) begin
          m_rd_valid = 1'b0;
          rcnt = 0;
        end else if (m_ren && !never_resp) begin
          rcnt++;
          if (rcnt > lat) begin
            m_rd_valid = 1'b1;
            m_rdata    = mem[m_addr[15:2]];
            rd_log.push_back(m_addr);
            rcnt = 0;
          end
        end else begin
          rcnt = 0;
        end
        if (m_ren) ren_cycles++;
        if (m_wen) begin
          wr_count++;
          if (m_wmask != 4'hF || m_addr[1:0] != 2'b00) bad_mask++;
          mem[m_addr[15:2]] = m_wdata;
          wr_log.push_back(m_addr);
          wr_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    s_addr = a; s_wdata = d; s_wen = 1'b1;
    @(negedge clk);
    s_wen = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    s_addr = a; s_ren = 1'b1;
    @(negedge clk);
    s_ren = 1'b0;
    if (!s_rd_valid) check("s_rd_valid", 32'(s_rd_valid), 32'd1);
    d = s_rdata;
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int k;
    k = 0;
    st = 32'h1;
    while (st[0] && k < 600) begin
      reg_read(R_CTRL, st);
      k++;
    end
    if (st[0]) check("wait_idle_bound", st, 32'h0);
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wr_count < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (wr_count < n) check("wait_writes_bound", 32'(wr_count), 32'(n));
  endtask

  function automatic int widx(input logic [15:0] base, input int i);
    return (int'(base[15:2]) + i) % 16384;
  endfunction

  // Reference: forward word-by-word copy, addresses wrap modulo 2^16
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int i = 0; i < 16384; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < n; i++) ref_mem[widx(d, i)] = ref_mem[widx(s, i)];
  endtask

  function automatic int mem_diffs();
    int c;
    c = 0;
    for (int i = 0; i < 16384; i++) if (mem[i] !== ref_mem[i]) c++;
    return c;
  endfunction

  task automatic clear_monitor();
    wr_count = 0; req_cycles = 0; ren_cycles = 0; bad_mask = 0;
    rd_log.delete(); wr_log.delete(); wr_cyc.delete();
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    reg_write(R_SRC, 32'(s));
    reg_write(R_DST, 32'(d));
    reg_write(R_LEN, 32'(n));
    clear_monitor();
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] rd;
    logic [15:0] rs, rdst;
    int rl;
    bit spacing_ok;

    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    s_addr = '0; s_ren = 1'b0; s_wen = 1'b0; s_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(|{m_req, m_ren, m_wen, m_addr, m_wdata, m_wmask,
                                  s_rdata, s_rd_valid, irq}), 32'd0);
    rst_n = 1'b1;

    // Register map vectors: optional write, then readback
    vecs[0] = '{1'b1, R_SRC,    32'hDEADBEEF, 32'h0000BEEC};
    vecs[1] = '{1'b1, R_DST,    32'h12345677, 32'h00005674};
    vecs[2] = '{1'b1, R_LEN,    32'hFFFF0005, 32'h00000005};
    vecs[3] = '{1'b0, R_REMAIN, 32'h0,        32'h00000000};
    vecs[4] = '{1'b0, 5'h14,    32'h0,        32'h00000000};
    vecs[5] = '{1'b0, 5'h1C,    32'h0,        32'h00000000};
    vecs[6] = '{1'b1, R_CTRL,   32'h00000002, 32'h00000004};
    vecs[7] = '{1'b1, R_CTRL,   32'h00000000, 32'h00000000};
    vecs[8] = '{1'b0, R_SRC,    32'h0,        32'h0000BEEC};
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].wdata);
      reg_read(vecs[i].addr, rd);
      check($sformatf("regmap[%0d]", i), rd, vecs[i].exp);
    end
    @(negedge clk);
    check("rd_valid_single_pulse", 32'(s_rd_valid), 32'd0);

    // Basic copy, 1-cycle responder
    for (int i = 0; i < 4; i++) mem[(16'h0100 >> 2) + i] = 32'h11111111 * 32'(i + 1);
    lat = 1; gdelay = 0;
    setup(16'h0100, 16'h8000, 16'd4);
    model_copy(16'h0100, 16'h8000, 4);
    reg_write(R_CTRL, 32'h3);
    wait_idle();
    check("basic_mem", 32'(mem_diffs()), 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("basic_word%0d", i), mem[(16'h8000 >> 2) + i], 32'h11111111 * 32'(i + 1));
    check("basic_wr_count", 32'(wr_count), 32'd4);
    check("basic_wmask", 32'(bad_mask), 32'd0);
    spacing_ok = (wr_cyc.size() == 4);
    for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 3) spacing_ok = 0;
    check("basic_3_cycles_per_word", 32'(spacing_ok), 32'd1);
    reg_read(R_CTRL, rd);
    check("basic_status", rd, 32'h6);
    reg_read(R_REMAIN, rd);
    check("basic_remain", rd, 32'd0);
    check("irq_on_done", 32'(irq), 32'd1);
    reg_write(R_CTRL, 32'h6);
    check("irq_after_clear_done", 32'(irq), 32'd0);

    // Zero length: done two cycles after the start write, no bus activity
    setup(16'h0100, 16'h8000, 16'd0);
    reg_write(R_CTRL, 32'h3);
    check("zero_len_irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    check("zero_len_irq_set", 32'(irq), 32'd1);
    repeat (4) @(negedge clk);
    check("zero_len_no_bus", 32'(req_cycles + ren_cycles + wr_count), 32'd0);
    reg_read(R_CTRL, rd);
    check("zero_len_status", rd, 32'h6);

    // Address wrap on source
    setup(16'hFFF8, 16'h4000, 16'd3);
    model_copy(16'hFFF8, 16'h4000, 3);
    reg_write(R_CTRL, 32'h1);
    wait_idle();
    check("wrap_rd_count", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() == 3) begin
      check("wrap_rd0", 32'(rd_log[0]), 32'hFFF8);
      check("wrap_rd1", 32'(rd_log[1]), 32'hFFFC);
      check("wrap_rd2", 32'(rd_log[2]), 32'h0000);
    end
    check("wrap_mem", 32'(mem_diffs()), 32'd0);
    reg_read(R_CTRL, rd);
    check("wrap_status", rd, 32'h2);

    // Read timeout: responder never answers
    never_resp = 1;
    setup(16'h0200, 16'h9000, 16'd2);
    model_copy(16'h0200, 16'h9000, 0);
    reg_write(R_CTRL, 32'h1);
    wait_idle();
    never_resp = 0;
    check("timeout_ren_cycles", 32'(ren_cycles), 32'd255);
    check("timeout_no_writes", 32'(wr_count), 32'd0);
    check("timeout_mem", 32'(mem_diffs()), 32'd0);
    reg_read(R_CTRL, rd);
    check("timeout_status", rd, 32'hA);
    reg_read(R_REMAIN, rd);
    check("timeout_remain", rd, 32'd2);

    // Abort after the 3rd write with a slow grant; LEN write mid-transfer ignored
    lat = 1; gdelay = 10;
    setup(16'h0300, 16'hA000, 16'd8);
    model_copy(16'h0300, 16'hA000, 4);
    reg_write(R_CTRL, 32'h1);
    wait_writes(1);
    reg_write(R_LEN, 32'h55);
    wait_writes(3);
    reg_write(R_CTRL, 32'h8);
    wait_idle();
    check("abort_wr_count", 32'(wr_count), 32'd4);
    check("abort_mem", 32'(mem_diffs()), 32'd0);
    reg_read(R_REMAIN, rd);
    check("abort_remain", rd, 32'd4);
    reg_read(R_CTRL, rd);
    check("abort_status", rd, 32'h2);
    reg_read(R_LEN, rd);
    check("abort_len_unchanged", rd, 32'd8);

    // Asynchronous reset in the middle of a transfer
    lat = 3; gdelay = 0;
    setup(16'h0400, 16'hB000, 16'd8);
    reg_write(R_CTRL, 32'h3);
    wait_writes(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(|{m_req, m_ren, m_wen, m_addr, m_wdata, m_wmask,
                                           s_rdata, s_rd_valid, irq}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reg_read(R_CTRL, rd);
    check("status_after_reset", rd, 32'h0);
    reg_read(R_REMAIN, rd);
    check("remain_after_reset", rd, 32'h0);

    // Randomized copies against the memory model
    for (int t = 0; t < 16; t++) begin
      rs   = 16'($urandom) & 16'hFFFC;
      rdst = 16'($urandom) & 16'hFFFC;
      rl   = $urandom_range(1, 6);
      lat  = $urandom_range(0, 3);
      gdelay = $urandom_range(0, 4);
      setup(rs, rdst, 16'(rl));
      model_copy(rs, rdst, rl);
      reg_write(R_CTRL, 32'h1);
      wait_idle();
      check($sformatf("rand%0d_mem", t), 32'(mem_diffs()), 32'd0);
      check($sformatf("rand%0d_wr_count", t), 32'(wr_count), 32'(rl));
      check($sformatf("rand%0d_wmask", t), 32'(bad_mask), 32'd0);
      reg_read(R_REMAIN, rd);
      check($sformatf("rand%0d_remain", t), rd, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
